alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller for an external ALU with a fixed latency.
// Keeps a 4 x 8-bit register file and registers the operands and select for the ALU.
// After ALU_LAT+2 edges it writes the ALU result back into the register file and
// reports the write-back for one cycle.
// Optional feature: define ALU_ISSUE_ZFLAG_EN to add the wb_zero result flag.
module alu_issue_ctrl #(
    parameter int unsigned ALU_LAT = 1  // legal range 0..7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [1:0] instr_rd,
    input  logic [1:0] instr_ra,
    input  logic [1:0] instr_rb,
    input  logic [7:0] instr_imm,
    input  logic       instr_use_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out,
    output logic       wb_valid,
    output logic [1:0] wb_rd,
    output logic [7:0] wb_data,
`ifdef ALU_ISSUE_ZFLAG_EN
    output logic       wb_zero,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StWait, StWb} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  rf_q [4];
    logic [7:0]  rf_d [4];
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [3:0]  alu_sel_q, alu_sel_d;
    logic [1:0]  rd_q, rd_d;  // destination of the instruction in flight
    logic        wb_valid_q, wb_valid_d;
    logic [1:0]  wb_rd_q, wb_rd_d;
    logic [7:0]  wb_data_q, wb_data_d;
`ifdef ALU_ISSUE_ZFLAG_EN
    logic        wb_zero_q, wb_zero_d;
`endif

    // Next-state: accept in idle, count down the ALU latency, then write back.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
`ifdef ALU_ISSUE_ZFLAG_EN
        wb_zero_d  = wb_zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    // Sources are read before any write, so rd == ra/rb sees the old value.
                    alu_a_d   = rf_q[instr_ra];
                    alu_b_d   = instr_use_imm ? instr_imm : rf_q[instr_rb];
                    alu_sel_d = instr_op;
                    rd_d      = instr_rd;
                    cnt_d     = 3'(ALU_LAT);
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWb: begin
                rf_d[rd_q] = alu_out;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = alu_out;
`ifdef ALU_ISSUE_ZFLAG_EN
                wb_zero_d  = (alu_out == 8'd0);
`endif
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset; reset drops any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            for (int i = 0; i < 4; i++) rf_q[i] <= 8'd0;
            alu_a_q    <= 8'd0;
            alu_b_q    <= 8'd0;
            alu_sel_q  <= 4'd0;
            rd_q       <= 2'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 2'd0;
            wb_data_q  <= 8'd0;
`ifdef ALU_ISSUE_ZFLAG_EN
            wb_zero_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
`ifdef ALU_ISSUE_ZFLAG_EN
            wb_zero_q  <= wb_zero_d;
`endif
        end
    end

    // Outputs come straight from state and registers.
    always_comb begin
        instr_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        alu_a       = alu_a_q;
        alu_b       = alu_b_q;
        alu_sel     = alu_sel_q;
        wb_valid    = wb_valid_q;
        wb_rd       = wb_rd_q;
        wb_data     = wb_data_q;
`ifdef ALU_ISSUE_ZFLAG_EN
        wb_zero     = wb_zero_q;
`endif
    end

endmodule
